// File: rtl/load_store_unit_pkg.sv
// Shared types and funct3 encodings for the RV32 load/store unit.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } lsu_state_t;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef struct packed {
    logic       we;
    logic       mis;
    logic [2:0] funct3;
    logic [1:0] off;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; word accesses ignore the low address bits.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sext;

  always_comb begin
    st_be    = 4'hF;
    st_wdata = st_data;
    unique case (1'b1)
      st_size == LS_B[1:0]: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      st_size == LS_H[1:0]: begin
        st_be    = 4'b0011 << {st_off[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[7:0];
    unique case (ld_off)
      2'd0: ld_byte = ld_rdata[7:0];
      2'd1: ld_byte = ld_rdata[15:8];
      2'd2: ld_byte = ld_rdata[23:16];
      2'd3: ld_byte = ld_rdata[31:24];
      default: ;
    endcase
  end

  assign ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
  assign ld_sext = ~ld_funct3[2];

  always_comb begin
    ld_data = ld_rdata;
    unique case (1'b1)
      ld_funct3[1:0] == LS_B[1:0]:
        ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      ld_funct3[1:0] == LS_H[1:0]:
        ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 data-memory access unit: one load/store, valid/ready to memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W instead of aligning down.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_mem_write,
  input  logic              ctrl_mem_read,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              lsu_stall,
  output logic              lsu_load_valid,
  output logic [DATA_W-1:0] lsu_load_data,
  output logic              lsu_misaligned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_be,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata
);

  lsu_state_t state_q, state_d;
  lsu_req_t   req_q;

  logic        start;
  logic        accept;
  logic        mis_now;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign start  = ctrl_mem_write | ctrl_mem_read;
  assign accept = (state_q == IDLE) & start;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_now = (funct3[1] & (|addr[1:0]))
                 | ((funct3[1:0] == LS_H[1:0]) & addr[0]);
  assign lsu_misaligned = (state_q == DONE) & req_q.mis;
`else
  assign mis_now        = 1'b0;
  assign lsu_misaligned = 1'b0;
`endif

  lsu_align u_align (
    .st_size   (funct3[1:0]),
    .st_off    (addr[1:0]),
    .st_data   (store_data),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (req_q.funct3),
    .ld_off    (req_q.off),
    .ld_rdata  (mem_rsp_rdata),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start) state_d = mis_now ? DONE : REQ;
      REQ:
        if (mem_req_valid & mem_req_ready)
          state_d = req_q.we ? DONE : WAIT_RSP;
      WAIT_RSP:
        if (mem_rsp_valid) state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Done cycle releases the pipeline so the held instruction retires once
  assign lsu_stall = accept
                   | (state_q == REQ)
                   | (state_q == WAIT_RSP);

  assign lsu_load_valid = (state_q == DONE)
                        & ~req_q.we
                        & ~req_q.mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_be    <= '0;
      lsu_load_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.we      <= ctrl_mem_write;
        req_q.mis     <= mis_now;
        req_q.funct3  <= funct3;
        req_q.off     <= addr[1:0];
        mem_req_valid <= ~mis_now;
        mem_req_we    <= ctrl_mem_write;
        mem_req_addr  <= {addr[ADDR_W-1:2], 2'b00};
        mem_req_wdata <= st_wdata;
        mem_req_be    <= st_be;
      end
      if ((state_q == REQ) & mem_req_ready)
        mem_req_valid <= 1'b0;
      if ((state_q == WAIT_RSP) & mem_rsp_valid)
        lsu_load_data <= ld_data;
    end
  end

endmodule
